// File: rtl/rom_stream_pkg.sv
// rtl/rom_stream_pkg.sv - shared state type and default parameters for rom_stream_reader
package rom_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_NUM_WORDS  = 1024;
  localparam int DEF_LATENCY    = 2;
  localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - first-word-fall-through output buffer with occupancy count
module stream_fifo
  import rom_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    cnt;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_rd   = rd_en && (cnt != '0);
  assign do_wr   = wr_en && (cnt != LW'(DEPTH));
  assign rd_data = mem[rd_ptr];
  assign empty   = (cnt == '0);
  assign level   = cnt;

  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) wr_ptr <= bump(wr_ptr);
      if (do_rd) rd_ptr <= bump(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/rom_stream_reader.sv
// rtl/rom_stream_reader.sv - bursts words out of a registered ROM into a ready/valid stream
// Optional running XOR output enabled by ROM_STREAM_CHECKSUM_EN.
module rom_stream_reader
  import rom_stream_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_WORDS  = DEF_NUM_WORDS,
  parameter int LATENCY    = DEF_LATENCY,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic                  rom_memenab,
  input  logic [WIDTH-1:0]      rom_q,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef ROM_STREAM_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]      checksum
`endif
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = $clog2(LATENCY + 2);

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] next_addr, last_addr, issue_addr;
  logic [ADDR_WIDTH:0]   remaining, remain_now;
  logic [LATENCY-1:0]    tag;
  logic [FW-1:0]         in_flight;
  logic [LW-1:0]         level;
  logic                  fifo_empty, issue, accept, xfer, last_xfer, zero_done, wr_en, room;

  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(NUM_WORDS - 1)) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  assign accept      = (state == IDLE) && start;
  assign xfer        = out_valid && out_ready;
  assign wr_en       = tag[LATENCY-1];
  assign room        = (int'(level) + int'(in_flight) + 1) <= FIFO_DEPTH;
  assign busy        = (state != IDLE);
  assign done        = zero_done || last_xfer;
  assign rom_memenab = 1'b1;
  assign out_valid   = !fifo_empty;
  assign rom_address = issue ? issue_addr : last_addr;

  // The first word is issued in the start cycle itself so the first out_valid
  // appears LATENCY+1 cycles after start.
  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    issue_addr = next_addr;
    remain_now = remaining;
    last_xfer  = 1'b0;
    case (state)
      IDLE: begin
        if (start && (count != '0)) begin
          issue      = 1'b1;
          issue_addr = base_addr;
          remain_now = count;
        end
      end
      ISSUE: issue = room;
      DRAIN: begin
        if ((in_flight == '0) && (level == LW'(1)) && xfer) begin
          last_xfer = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (issue) begin
      state_nx = (remain_now == (ADDR_WIDTH + 1)'(1)) ? DRAIN : ISSUE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      next_addr <= '0;
      last_addr <= '0;
      remaining <= '0;
      tag       <= '0;
      in_flight <= '0;
      zero_done <= 1'b0;
    end else begin
      state     <= state_nx;
      zero_done <= accept && (count == '0);
      tag       <= (tag << 1) | LATENCY'(issue);
      if (issue) begin
        last_addr <= issue_addr;
        next_addr <= wrap_inc(issue_addr);
        remaining <= remain_now - (ADDR_WIDTH + 1)'(1);
      end
      case ({issue, wr_en})
        2'b10:   in_flight <= in_flight + FW'(1);
        2'b01:   in_flight <= in_flight - FW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (rom_q),
    .rd_en   (xfer),
    .rd_data (out_data),
    .empty   (fifo_empty),
    .level   (level)
  );

`ifdef ROM_STREAM_CHECKSUM_EN
  always_ff @(posedge clock) begin
    if (reset || accept) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum ^ out_data;
    end
  end
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb/tb_rom_stream_reader.sv - scoreboard bench for rom_stream_reader with a registered ROM model
module tb_rom_stream_reader;

  localparam int AW = 10;
  localparam int W  = 32;

  logic          clock, reset, start, busy, done, rom_memenab, out_valid, out_ready;
  logic [AW-1:0] base_addr, rom_address, rom_addr_q;
  logic [AW:0]   count;
  logic [W-1:0]  rom_q, out_data;
`ifdef ROM_STREAM_CHECKSUM_EN
  logic [W-1:0]  checksum;
`endif

  int           n_vec = 0;
  int           n_err = 0;
  int           done_cnt = 0;
  int           cyc = 0;
  int           start_cyc = 0;
  int           max_level = 0;
  int           bp_k = 0;
  int           d0;
  logic         bp_en = 1'b0;
  logic         expect_last = 1'b0;
  logic [3:0]   bp_pat = 4'b1001;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [W-1:0] exp_q[$];

  rom_stream_reader dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .rom_address (rom_address),
    .rom_memenab (rom_memenab),
    .rom_q       (rom_q),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
`ifdef ROM_STREAM_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  // Address 100..102 hold 1, 2, 4; every other word is 0xC0DE0000 | address.
  function automatic logic [W-1:0] rom_word(input logic [AW-1:0] a);
    if (a >= 10'd100 && a <= 10'd102) return 32'h1 << (a - 10'd100);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    rom_addr_q <= rom_address;
    rom_q      <= rom_word(rom_addr_q);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (bp_en) begin
        out_ready = bp_pat[bp_k];
        bp_k = (bp_k + 1) % 4;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks stream rules.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: got %0h expected none", out_data);
          end else begin
            check("data", out_data, exp_q.pop_front());
          end
        end
        if (done) begin
          done_cnt++;
          if (expect_last) check("done_on_last", {(out_valid && out_ready), (exp_q.size() == 0)}, 2'b11);
          else check("done_no_xfer", (out_valid && out_ready), 0);
        end
        if (int'(dut.level) > max_level) max_level = int'(dut.level);
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic start_burst(input logic [AW-1:0] b, input logic [AW:0] c);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    start_cyc = cyc;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d, n;
    d = done_cnt;
    n = 0;
    while (done_cnt == d && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_done_seen"}, done_cnt - d, 1);
    tick(2);
    check({name, "_done_once"}, done_cnt - d, 1);
    check({name, "_all_words"}, exp_q.size(), 0);
    check({name, "_idle"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; count = '0;
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_addr", rom_address, 0);
    check("memenab", rom_memenab, 1);
`ifdef ROM_STREAM_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif
    reset = 1'b0;
    tick(2);

    // Burst base=5 count=8
    expect_last = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(rom_word(AW'(5 + i)));
    start_burst(10'd5, 11'd8);
    check("burst_busy", busy, 1);
    while (!out_valid && (cyc - start_cyc) < 20) @(negedge clock);
    check("first_valid_latency", cyc - start_cyc, 3);
    tick(1);
    wait_done("burst", 40);

    // Zero-length request
    expect_last = 1'b0;
    d0 = done_cnt;
    start_burst(10'd7, 11'd0);
    check("zero_done_pulse", done, 1);
    check("zero_busy", busy, 0);
    tick(1);
    check("zero_done_low", done, 0);
    check("zero_valid", out_valid, 0);
    tick(3);
    check("zero_done_count", done_cnt - d0, 1);

    // Address wrap at the top of the ROM
    expect_last = 1'b1;
    exp_q.push_back(32'hC0DE_03FE);
    exp_q.push_back(32'hC0DE_03FF);
    exp_q.push_back(32'hC0DE_0000);
    exp_q.push_back(32'hC0DE_0001);
    start_burst(10'd1022, 11'd4);
    wait_done("wrap", 40);

    // Backpressure 1,0,0,1 over 16 words
    bp_en = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(rom_word(AW'(300 + i)));
    start_burst(10'd300, 11'd16);
    wait_done("bp", 200);
    bp_en = 1'b0;
    check("bp_max_level_le4", (max_level <= 4), 1);
    tick(2);

    // Reset two cycles into a 16-word burst
    for (int i = 0; i < 16; i++) exp_q.push_back(rom_word(AW'(500 + i)));
    start_burst(10'd500, 11'd16);
    tick(1);
    reset = 1'b1;
    tick(1);
    exp_q.delete();
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_addr", rom_address, 0);
    reset = 1'b0;
    d0 = done_cnt;
    tick(8);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_quiet", out_valid, 0);

    for (int i = 0; i < 6; i++) exp_q.push_back(rom_word(AW'(40 + i)));
    start_burst(10'd40, 11'd6);
    wait_done("post_rst", 40);

`ifdef ROM_STREAM_CHECKSUM_EN
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h4);
    start_burst(10'd100, 11'd3);
    wait_done("cks", 40);
    check("checksum_xor", checksum, 32'h7);
    expect_last = 1'b0;
    start_burst(10'd0, 11'd0);
    check("checksum_clear", checksum, 0);
    tick(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
